// File: rtl/du_pkg.sv
// Shared constants and FSM encoding for the debug snapshot transmitter.
// Snapshot layout is {pad, ID/EX, IF/ID, mem window, register file}, LSB first on the wire.
package du_pkg;

    localparam int REG_W       = 1024;
    localparam int MEM_W       = 256;
    localparam int IFID_W      = 64;
    localparam int IDEX_W      = 126;
    localparam int SNAP_W      = 1472;
    localparam int SNAP_BYTES  = 184;
    localparam int FRAME_BYTES = 186;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
    localparam logic [7:0] LAST_IDX       = 8'(SNAP_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_HDR  = 3'd1,
        SEND_PAY  = 3'd2,
        SEND_CSUM = 3'd3,
        DONE      = 3'd4
    } du_state_e;

    // Running XOR checksum over payload bytes.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/debug_snapshot_tx_if.sv
// Byte handshake between the frame sequencer and the UART transmitter.
interface debug_snapshot_tx_if;
    logic       start;
    logic [7:0] data;
    logic       ready;

    modport master (output start, output data, input ready);
    modport slave  (input start, input data, output ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts one byte per start pulse while ready, idles high.
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                 clk,
    input  logic                 reset,
    debug_snapshot_tx_if.slave   link,
    output logic                 tx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] baud_cnt_r;
    logic [3:0]    bit_idx_r;
    logic [8:0]    shift_r;
    logic          ready_r;
    logic          tx_r;
    logic          bit_end_s;

    // End of the current bit period.
    always_comb begin
        bit_end_s = (baud_cnt_r == CW'(CLKS_PER_BIT - 1));
    end

    // Bit sequencer: bit 0 is the start bit, bit 9 the stop bit; ready returns after the stop bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= 4'd0;
            shift_r    <= 9'h1FF;
            ready_r    <= 1'b1;
            tx_r       <= 1'b1;
        end else if (ready_r) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= 4'd0;
            if (link.start) begin
                tx_r    <= 1'b0;
                shift_r <= {1'b1, link.data};
                ready_r <= 1'b0;
            end else begin
                tx_r    <= 1'b1;
            end
        end else if (bit_end_s) begin
            baud_cnt_r <= '0;
            if (bit_idx_r == 4'd9) begin
                ready_r <= 1'b1;
            end else begin
                tx_r      <= shift_r[0];
                shift_r   <= {1'b1, shift_r[8:1]};
                bit_idx_r <= bit_idx_r + 4'd1;
            end
        end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
        end
    end

    assign link.ready = ready_r;
    assign tx         = tx_r;

endmodule

// File: rtl/debug_snapshot_tx.sv
// Latches a CPU debug snapshot on halt edge or manual request and streams it
// over UART as HEADER, 184 payload bytes, XOR checksum.
module debug_snapshot_tx
    import du_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 5208,
    parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  du_reg,
    input  logic [MEM_W-1:0]  du_mem,
    input  logic [IFID_W-1:0] du_if_id,
    input  logic [IDEX_W-1:0] du_id_ex,
    input  logic              du_halt,
    input  logic              dump_req,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    du_state_e         state_r, state_next_s;
    logic [SNAP_W-1:0] snap_r;
    logic [7:0]        idx_r;
    logic [7:0]        csum_r;
    logic              csum_sent_r;
    logic              halt_q_r;
    logic              busy_r;
    logic              done_r;
    logic              trigger_s;
    logic              start_s;
    logic [7:0]        data_s;
    logic [7:0]        pay_byte_s;

    debug_snapshot_tx_if link ();

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk   (clk),
        .reset (reset),
        .link  (link.slave),
        .tx    (tx)
    );

    // Trigger detection and payload byte selection.
    always_comb begin
        trigger_s  = (state_r == IDLE) && ((du_halt && !halt_q_r) || dump_req);
        pay_byte_s = snap_r[{idx_r, 3'b000} +: 8];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:      if (trigger_s) state_next_s = SEND_HDR;  else state_next_s = IDLE;
            SEND_HDR:  if (start_s)   state_next_s = SEND_PAY;  else state_next_s = SEND_HDR;
            SEND_PAY:  if (start_s && (idx_r == LAST_IDX)) state_next_s = SEND_CSUM;
                       else state_next_s = SEND_PAY;
            SEND_CSUM: if (csum_sent_r && link.ready) state_next_s = DONE;
                       else state_next_s = SEND_CSUM;
            DONE:      state_next_s = IDLE;
            default:   state_next_s = IDLE;
        endcase
    end

    // FSM outputs: byte offered to the UART and its one-cycle start strobe.
    always_comb begin
        start_s = 1'b0;
        data_s  = 8'h00;
        case (state_r)
            SEND_HDR: begin
                start_s = link.ready;
                data_s  = HEADER;
            end
            SEND_PAY: begin
                start_s = link.ready;
                data_s  = pay_byte_s;
            end
            SEND_CSUM: begin
                start_s = link.ready && !csum_sent_r;
                data_s  = csum_r;
            end
            default: begin
                start_s = 1'b0;
                data_s  = 8'h00;
            end
        endcase
    end

    assign link.start = start_s;
    assign link.data  = data_s;

    // Snapshot, byte index, checksum and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_q_r    <= 1'b1;
            snap_r      <= '0;
            idx_r       <= 8'd0;
            csum_r      <= 8'h00;
            csum_sent_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            halt_q_r <= du_halt;
            busy_r   <= (state_next_s == SEND_HDR) || (state_next_s == SEND_PAY) ||
                        (state_next_s == SEND_CSUM);
            done_r   <= (state_next_s == DONE);
            if (trigger_s) begin
                snap_r      <= {2'b00, du_id_ex, du_if_id, du_mem, du_reg};
                idx_r       <= 8'd0;
                csum_r      <= 8'h00;
                csum_sent_r <= 1'b0;
            end else begin
                if ((state_r == SEND_PAY) && start_s) begin
                    idx_r  <= idx_r + 8'd1;
                    csum_r <= csum_next(csum_r, pay_byte_s);
                end
                if ((state_r == SEND_CSUM) && start_s) begin
                    csum_sent_r <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule
